// File: rtl/des_axil_slave.sv
// AXI4-Lite register front end for the DES peripheral: key/data/control
// registers, start pulse generation and result capture.
module des_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [2*C_S_AXI_DATA_WIDTH-1:0]   des_key,
   output logic [2*C_S_AXI_DATA_WIDTH-1:0]   des_din,
   output logic                              des_decrypt,
   output logic                              des_start,
   input  logic                              des_busy,
   input  logic                              des_done,
   input  logic [2*C_S_AXI_DATA_WIDTH-1:0]   des_dout
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int AW = C_S_AXI_ADDR_WIDTH;

   localparam logic [2:0] IDX_KEY_LO  = 3'd0;
   localparam logic [2:0] IDX_KEY_HI  = 3'd1;
   localparam logic [2:0] IDX_DIN_LO  = 3'd2;
   localparam logic [2:0] IDX_DIN_HI  = 3'd3;
   localparam logic [2:0] IDX_CTRL    = 3'd4;
   localparam logic [2:0] IDX_STATUS  = 3'd5;
   localparam logic [2:0] IDX_DOUT_LO = 3'd6;
   localparam logic [2:0] IDX_DOUT_HI = 3'd7;

   logic          aw_held_q, aw_held_d;
   logic [AW-1:0] aw_addr_q, aw_addr_d;
   logic          w_held_q, w_held_d;
   logic [DW-1:0] w_data_q, w_data_d;
   logic [SW-1:0] w_strb_q, w_strb_d;
   logic          bvalid_q, bvalid_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] key_lo_q, key_lo_d, key_hi_q, key_hi_d;
   logic [DW-1:0] din_lo_q, din_lo_d, din_hi_q, din_hi_d;
   logic [DW-1:0] dout_lo_q, dout_lo_d, dout_hi_q, dout_hi_d;
   logic          decrypt_q, decrypt_d;
   logic          done_q, done_d;
   logic          start_q, start_d;

   logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic          do_write, start_accept;
   logic [2:0]    wr_idx;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] wr_strb;
   logic [DW-1:0] rd_word;
   logic          unused_ok;

   function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int i = 0; i < SW; i++) begin
         if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   assign S_AXI_AWREADY = ~aw_held_q;
   assign S_AXI_WREADY  = ~w_held_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ~rvalid_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

   assign des_key     = {key_hi_q, key_lo_q};
   assign des_din     = {din_hi_q, din_lo_q};
   assign des_decrypt = decrypt_q;
   assign des_start   = start_q;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[1:0], aw_addr_q[1:0]};

   // Write channel: a channel arriving this cycle is used directly so the
   // same-cycle AW+W case commits on its handshake edge.
   always_comb begin
      aw_hs   = S_AXI_AWVALID & ~aw_held_q;
      w_hs    = S_AXI_WVALID & ~w_held_q;
      b_hs    = bvalid_q & S_AXI_BREADY;
      wr_idx  = aw_held_q ? aw_addr_q[4:2] : S_AXI_AWADDR[4:2];
      wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
      wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
      do_write = (aw_held_q | S_AXI_AWVALID) & (w_held_q | S_AXI_WVALID) & ~bvalid_q;
      start_accept = do_write && (wr_idx == IDX_CTRL) && wr_strb[0] && wr_data[0] && !des_busy;

      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = S_AXI_AWADDR;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end
      // Holding registers stay occupied until B completes, keeping ready low.
      if (do_write) begin
         bvalid_d = 1'b1;
      end else if (b_hs) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
   end

   // Register file update, start pulse and result capture.
   always_comb begin
      key_lo_d  = key_lo_q;
      key_hi_d  = key_hi_q;
      din_lo_d  = din_lo_q;
      din_hi_d  = din_hi_q;
      decrypt_d = decrypt_q;
      dout_lo_d = dout_lo_q;
      dout_hi_d = dout_hi_q;
      done_d    = done_q;
      start_d   = start_accept;
      if (do_write) begin
         case (wr_idx)
            IDX_KEY_LO: key_lo_d = merge_strb(key_lo_q, wr_data, wr_strb);
            IDX_KEY_HI: key_hi_d = merge_strb(key_hi_q, wr_data, wr_strb);
            IDX_DIN_LO: din_lo_d = merge_strb(din_lo_q, wr_data, wr_strb);
            IDX_DIN_HI: din_hi_d = merge_strb(din_hi_q, wr_data, wr_strb);
            IDX_CTRL:   if (wr_strb[0]) decrypt_d = wr_data[1];
            default: ;
         endcase
      end
      if (des_done) begin
         dout_lo_d = des_dout[DW-1:0];
         dout_hi_d = des_dout[2*DW-1:DW];
         done_d    = 1'b1;
      end
      // A new accepted start wins over a coincident completion for DONE.
      if (start_accept) done_d = 1'b0;
   end

   // Read channel: data is taken from current register state, so a
   // coincident write to the same register is not yet visible.
   always_comb begin
      ar_hs = S_AXI_ARVALID & ~rvalid_q;
      r_hs  = rvalid_q & S_AXI_RREADY;
      case (S_AXI_ARADDR[4:2])
         IDX_KEY_LO:  rd_word = key_lo_q;
         IDX_KEY_HI:  rd_word = key_hi_q;
         IDX_DIN_LO:  rd_word = din_lo_q;
         IDX_DIN_HI:  rd_word = din_hi_q;
         IDX_CTRL:    rd_word = DW'({decrypt_q, 1'b0});
         IDX_STATUS:  rd_word = DW'({done_q, des_busy});
         IDX_DOUT_LO: rd_word = dout_lo_q;
         IDX_DOUT_HI: rd_word = dout_hi_q;
         default:     rd_word = '0;
      endcase
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
      end else if (r_hs) begin
         rvalid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         key_lo_q  <= '0;
         key_hi_q  <= '0;
         din_lo_q  <= '0;
         din_hi_q  <= '0;
         dout_lo_q <= '0;
         dout_hi_q <= '0;
         decrypt_q <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         key_lo_q  <= key_lo_d;
         key_hi_q  <= key_hi_d;
         din_lo_q  <= din_lo_d;
         din_hi_q  <= din_hi_d;
         dout_lo_q <= dout_lo_d;
         dout_hi_q <= dout_hi_d;
         decrypt_q <= decrypt_d;
         done_q    <= done_d;
         start_q   <= start_d;
      end
   end

endmodule

// File: doc/des_axil_slave.md
# des_axil_slave

AXI4-Lite responder that is the register front end of the DES encryption peripheral, sitting behind the S00_AXI port that the block-design master drives. It holds the 64-bit key and data words and a control/status pair, issues a one-cycle start pulse to the DES core, and captures the core's 64-bit result for readback. Supports independent write-address and write-data arrival and one outstanding transaction per channel.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[4:2]

- S_AXI_ACLK  in  1  sole clock, rising edge
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  5/3/1/1  write address channel (AWPROT ignored)
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  5/3/1/1  read address (ARPROT ignored)
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data
- des_key  out  64  {KEY_HI, KEY_LO}
- des_din  out  64  {DIN_HI, DIN_LO}
- des_decrypt  out  1  CTRL[1]
- des_start  out  1  one-cycle start pulse
- des_busy  in  1  core busy
- des_done  in  1  one-cycle completion pulse
- des_dout  in  64  core result, valid when des_done=1

## Operation
- Register map (word index): 0 KEY_LO RW, 1 KEY_HI RW, 2 DIN_LO RW, 3 DIN_HI RW, 4 CTRL, 5 STATUS RO, 6 DOUT_LO RO, 7 DOUT_HI RO.
- CTRL: bit0 START (write-1 pulse, reads 0), bit1 DECRYPT (RW); other bits read 0.
- STATUS: bit0 = des_busy (live), bit1 = DONE (sticky); other bits 0.
- Writes honour WSTRB per byte; writes to RO indices are dropped silently; BRESP and RRESP always OKAY (2'b00).
- Write path: AW and W are latched independently into holding registers (AWREADY deasserts once AW held, WREADY once W held). When both are held and BVALID=0, the register update happens and BVALID is asserted the next edge; holding registers are released when B handshakes.
- Read path: ARREADY=1 whenever RVALID=0; on AR handshake RDATA is registered and RVALID=1 the next cycle; held stable until RREADY.
- Start: a write to CTRL with WSTRB[0]=1 and WDATA[0]=1 pulses des_start for exactly one cycle, concurrent with the register update, only if des_busy=0; otherwise ignored (no pulse, DECRYPT still updated).
- On des_done: DOUT_LO/HI <= des_dout[31:0]/[63:32], DONE <= 1.
- Accepted start clears DONE; if des_done and an accepted start occur in the same cycle, DOUT is captured and DONE ends 0.

## Timing
- Reset (asynchronous assert, synchronous release): all data registers 0, DONE 0, AWREADY/WREADY/ARREADY 1, BVALID/RVALID 0, BRESP/RRESP 0, RDATA 0, des_start 0.
- Reset mid-transaction aborts it; no B or R response is issued afterwards.
- Write latency: AW and W in same cycle -> register updated and BVALID=1 on the next edge; AW/W on different cycles -> update one edge after the later handshake.
- Back-to-back writes: next AW/W accepted in the cycle after B handshake (ready lines reassert then); throughput one write per 2 cycles minimum.
- Read latency 1 cycle; throughput one read per 2 cycles with RREADY held high.
- Simultaneous read and write to the same register: read returns the pre-write value.
- STATUS.busy sampled at AR handshake.

## Test plan
- Sequential write/readback: write 0x1,0x2,0x3,0x4 to indices 0-3 -> reads return 0x1..0x4, all BRESP/RRESP=0.
- WSTRB: write 0xAABBCCDD to KEY_LO with WSTRB=4'b0101 after it holds 0 -> readback 0x00BB00DD.
- Split AW/W: AWVALID 3 cycles before WVALID, BREADY low 4 cycles -> single update, BVALID held until BREADY, no second write.
- Start flow: busy=0, write CTRL=0x3 -> des_start one cycle, des_decrypt=1, DONE=0; core returns des_done with dout 0x0123456789ABCDEF -> STATUS=0x2, DOUT_LO=0x89ABCDEF, DOUT_HI=0x01234567.
- Start while busy: des_busy=1, write CTRL=0x1 -> no des_start pulse, STATUS bit0=1, DONE unchanged.
- RO and reset: write 0xFFFFFFFF to index 6 -> readback unchanged; drop ARESETN mid-read with RVALID pending -> RVALID 0 immediately, all registers read 0 after release.
